// File: rtl/output_uart_pkg.sv
// Shared definitions for the serial output stage: FSM encoding and default sizing.
package output_uart_pkg;

    // UART transmitter states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DATA_BITS            = 8;

    // Index of the last data bit of a frame
    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

endpackage

// File: rtl/output_uart_byte_fifo.sv
// Small first-word-fall-through byte FIFO with a registered occupancy count.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module output_uart_byte_fifo
    import output_uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATA_BITS-1:0] din_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic [LW-1:0]        level_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [LW-1:0]        count_q;
    logic [LW-1:0]        count_d;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    assign full_o    = (count_q == DEPTH_L);
    assign empty_o   = (count_q == {LW{1'b0}});
    assign level_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Next occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + LEVEL_ONE;
            2'b01:   count_d = count_q - LEVEL_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage, wrapping pointers and occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/output_uart.sv
// Serial console output stage: queues bytes strobed by doOut and sends them 8N1,
// LSB first, on a registered tx line. A full FIFO drops the byte and sets a sticky flag.
module output_uart
    import output_uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter  int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          doOut,
    input  logic [7:0]    dbus,
    output logic          tx,
    output logic          busy,
    output logic          full,
    output logic          overflow,
    output logic [LW-1:0] level
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    uart_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          overflow_q;

    logic          timer_zero_s;
    logic          pop_s;
    logic          drop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [7:0]    fifo_head_s;
    logic [LW-1:0] fifo_level_s;

    output_uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_byte_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (doOut),
        .pop_i   (pop_s),
        .din_i   (dbus),
        .dout_o  (fifo_head_s),
        .level_o (fifo_level_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign timer_zero_s = (timer_q == {TW{1'b0}});
    assign drop_s       = doOut & fifo_full_s & ~pop_s;

    // Pop the head when starting a frame from idle or chaining straight out of a stop bit
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            ST_IDLE: pop_s = ~fifo_empty_s;
            ST_STOP: pop_s = timer_zero_s & ~fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Transmit FSM with bit timer, bit index, shift register and registered tx
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= {TW{1'b0}};
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty_s) begin
                        shift_q <= fifo_head_s;
                        tx_q    <= 1'b0;
                        timer_q <= TIMER_MAX;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_zero_s) begin
                        tx_q    <= shift_q[0];
                        idx_q   <= 3'd0;
                        timer_q <= TIMER_MAX;
                        state_q <= ST_DATA;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_DATA: begin
                    if (timer_zero_s) begin
                        timer_q <= TIMER_MAX;
                        if (idx_q == LAST_BIT_IDX) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_STOP: begin
                    if (timer_zero_s) begin
                        if (!fifo_empty_s) begin
                            shift_q <= fifo_head_s;
                            tx_q    <= 1'b0;
                            timer_q <= TIMER_MAX;
                            state_q <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: set when a strobed byte cannot be queued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop_s) begin
            overflow_q <= 1'b1;
        end else begin
            overflow_q <= overflow_q;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign full     = fifo_full_s;
    assign level    = fifo_level_s;
    assign busy     = (state_q != ST_IDLE) | ~fifo_empty_s;

endmodule

// File: tb/tb_output_uart.sv
// Directed bench for output_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_output_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          doOut = 1'b0;
    logic [7:0]    dbus = 8'h00;
    logic          tx;
    logic          busy;
    logic          full;
    logic          overflow;
    logic [LW-1:0] level;

    int total = 0;
    int bad   = 0;

    output_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .doOut    (doOut),
        .dbus     (dbus),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent 8N1 receiver: samples mid-bit, one sample per cycle just after the edge
    logic [7:0] rx_q[$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 2) check("rx_start_bit", tx, 0);
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh[(rx_cnt - 6) / 4] = tx;
                if (rx_cnt == 38) begin
                    check("rx_stop_bit", tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic d, input logic [7:0] b);
        doOut = d;
        dbus  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        doOut   = 1'b0;
        dbus    = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (busy === 1'b1 && i < budget) begin
            tick(1'b0, 8'h00);
            i++;
        end
        check(name, busy, 0);
    endtask

    // Push n (1..3) bytes on consecutive edges and check the whole tx waveform
    task automatic run_frames(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int n);
        logic [7:0] bs[3];
        logic       exp;
        int         f;
        int         p;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        tick(1'b1, bs[0]);
        check({name, "_edge0_tx"}, tx, 1);
        check({name, "_edge0_busy"}, busy, 1);
        for (int c = 1; c <= 40 * n; c++) begin
            if (c < n) tick(1'b1, bs[c]);
            else       tick(1'b0, 8'h00);
            f = (c - 1) / 40;
            p = ((c - 1) % 40) / 4;
            if (p == 0)      exp = 1'b0;
            else if (p == 9) exp = 1'b1;
            else             exp = bs[f][p - 1];
            check($sformatf("%s_tx_c%0d", name, c), tx, exp);
        end
        check({name, "_busy_last"}, busy, 1);
        tick(1'b0, 8'h00);
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_idle_tx"}, tx, 1);
    endtask

    typedef struct {
        logic          do_out;
        logic [7:0]    din;
        logic          e_tx;
        logic          e_busy;
        logic          e_full;
        logic          e_ovf;
        logic [LW-1:0] e_level;
    } vec_t;

    vec_t       vtab[7];
    logic [7:0] exp_q[$];
    bit         flag;
    logic [7:0] rb;
    int         gap;

    initial begin
        // Six pushes on consecutive edges from idle; state after each edge
        vtab[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        vtab[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        vtab[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vtab[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
        vtab[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        vtab[5] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4};
        vtab[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4};

        // Reset state
        reset_n = 1'b0;
        #12;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", level, 0);
        do_reset();

        // 1: single byte A5
        rx_q.delete();
        run_frames("t1", 8'hA5, 8'h00, 8'h00, 1);
        check("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t1_rx_byte", rx_q[0], 8'hA5);

        // 2: three bytes back to back
        do_reset();
        rx_q.delete();
        run_frames("t2", 8'h01, 8'h02, 8'h03, 3);
        check("t2_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) check($sformatf("t2_rx_%0d", i), rx_q[i], i + 1);

        // 3: overflow table
        do_reset();
        rx_q.delete();
        for (int i = 0; i < 7; i++) begin
            tick(vtab[i].do_out, vtab[i].din);
            check($sformatf("t3_tx_%0d", i), tx, vtab[i].e_tx);
            check($sformatf("t3_busy_%0d", i), busy, vtab[i].e_busy);
            check($sformatf("t3_full_%0d", i), full, vtab[i].e_full);
            check($sformatf("t3_ovf_%0d", i), overflow, vtab[i].e_ovf);
            check($sformatf("t3_level_%0d", i), level, vtab[i].e_level);
        end
        wait_idle("t3_drain", 400);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) check($sformatf("t3_rx_%0d", i), rx_q[i], vtab[i].din);

        // 4: push on a full FIFO on the same edge as the STOP->START pop
        do_reset();
        rx_q.delete();
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        tick(1'b1, 8'h55);
        repeat (36) tick(1'b0, 8'h00);
        check("t4_pre_level", level, 4);
        check("t4_pre_full", full, 1);
        check("t4_pre_tx_stop", tx, 1);
        tick(1'b1, 8'h66);
        check("t4_level", level, 4);
        check("t4_full", full, 1);
        check("t4_ovf", overflow, 0);
        check("t4_tx_nogap", tx, 0);
        wait_idle("t4_drain", 400);
        check("t4_ovf_end", overflow, 0);
        check("t4_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) check($sformatf("t4_rx_%0d", i), rx_q[i], 8'h11 * (i + 1));

        // 5: reset mid-DATA of FF with two bytes queued
        do_reset();
        rx_q.delete();
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hA1);
        tick(1'b1, 8'hB2);
        repeat (7) tick(1'b0, 8'h00);
        check("t5_pre_level", level, 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_tx", tx, 1);
        check("t5_level", level, 0);
        check("t5_busy", busy, 0);
        check("t5_full", full, 0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // reset while tx is driving a low data bit must raise the line at once
        tick(1'b1, 8'h00);
        repeat (9) tick(1'b0, 8'h00);
        check("t5b_pre_tx", tx, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5b_tx", tx, 1);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        flag = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) flag = 1'b0;
        end
        check("t5_line_idle", flag, 1);
        tick(1'b1, 8'h5A);
        tick(1'b0, 8'h00);
        check("t5_restart_tx", tx, 0);
        wait_idle("t5_drain", 100);
        check("t5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t5_rx_byte", rx_q[0], 8'h5A);

        // 6: random bytes with spacing of at least one frame
        do_reset();
        rx_q.delete();
        exp_q.delete();
        flag = 1'b0;
        for (int k = 0; k < 256; k++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(rb);
            tick(1'b1, rb);
            if (overflow !== 1'b0) flag = 1'b1;
            gap = $urandom_range(40, 52);
            for (int g = 1; g < gap; g++) begin
                tick(1'b0, 8'h00);
                if (overflow !== 1'b0) flag = 1'b1;
            end
        end
        wait_idle("t6_drain", 200);
        check("t6_ovf_never", flag, 0);
        check("t6_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) check($sformatf("t6_rx_%0d", i), rx_q[i], exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
